// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared state encoding and operand-width legality check.
package serial_add_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  function automatic bit width_ok(int w);
    return (w >= 2) && (w % 2 == 0);
  endfunction
endpackage

// File: rtl/adder_2bit_ci.sv
// adder_2bit_ci: 2-bit ripple slice with carry-in, exposing the carry into bit 1.
module adder_2bit_ci (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       c_in,
  output logic [1:0] sum,
  output logic       c_mid,
  output logic       c_out
);
  full_adder u_fa0 (.a(a[0]), .b(b[0]), .ci(c_in),  .s(sum[0]), .co(c_mid));
  full_adder u_fa1 (.a(a[1]), .b(b[1]), .ci(c_mid), .s(sum[1]), .co(c_out));
endmodule

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds two WIDTH-bit operands two bits per clock through one 2-bit slice.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum_out,
  output logic             c_out,
  output logic             ovf
);
  localparam int SLICES = WIDTH / 2;
  localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;
  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH must be even and >= 2");
  end
  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [1:0]       s_sum;
  logic             s_mid, s_cout, last;
  adder_2bit_ci u_slice (
    .a(opa_q[1:0]), .b(opb_q[1:0]), .c_in(carry_q),
    .sum(s_sum), .c_mid(s_mid), .c_out(s_cout)
  );
  assign last = cnt_q == CW'(SLICES - 1);
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        opa_d   = A;
        opb_d   = B;
        carry_d = 1'b0;
        cnt_d   = '0;
      end
      RUN: begin
        opa_d   = opa_q >> 2;
        opb_d   = opb_q >> 2;
        // slice result enters from the top so the LSB slice ends at bit 0
        res_d   = WIDTH'({s_sum, res_q} >> 2);
        carry_d = s_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          sum_d   = res_d;
          cout_d  = s_cout;
          ovf_d   = s_cout ^ s_mid;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign Sum_out = sum_q;
  assign c_out   = cout_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed checks of the serial adder controller at WIDTH=8 and WIDTH=2.
module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       reset, start, start2;
  logic [7:0] a, b, sum;
  logic [1:0] a2, b2, sum2;
  logic       busy, done, cout, ovf, busy2, done2, cout2, ovf2;
  int         checks = 0, errors = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .A(a), .B(b),
    .busy(busy), .done(done), .Sum_out(sum), .c_out(cout), .ovf(ovf)
  );
  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .A(a2), .B(b2),
    .busy(busy2), .done(done2), .Sum_out(sum2), .c_out(cout2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_add(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] es, input logic ec, input logic eo);
    int n = 0;
    a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
    a = 8'hA5; b = 8'h5A;
    chk({tag, "_busy"}, 32'(busy), 1);
    while (!done && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    step();
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_sum_held"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    a = '0; b = '0; a2 = '0; b2 = '0;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_out", {cout, ovf, sum}, 0);
      step();
    end

    run_add("5a_3c", 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
    run_add("ff_01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_add("80_80", 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);

    a = 8'h11; b = 8'h22; start = 1'b1;
    step();
    a = 8'hFF; b = 8'hFF;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done) begin
        n++;
        chk("ign_sum_at_done", 32'(sum), 32'h33);
      end
    end
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) n++;
    end
    chk("ign_done_count", n, 1);
    chk("ign_sum", 32'(sum), 32'h33);
    chk("ign_idle", 32'(busy), 0);

    a = 8'h0F; b = 8'h01; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("abort_busy_before", 32'(busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_out", {done, cout, ovf, sum}, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) n++;
    end
    chk("abort_no_done", n, 0);
    chk("abort_sum_held", 32'(sum), 0);
    run_add("01_01", 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

    reset = 1'b1; start = 1'b1;
    step();
    reset = 1'b0; start = 1'b0;
    chk("rst_wins", 32'(busy), 0);

    a2 = 2'b11; b2 = 2'b01; start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("w2_busy", 32'(busy2), 1);
    chk("w2_not_done_yet", 32'(done2), 0);
    step();
    chk("w2_done", 32'(done2), 1);
    chk("w2_sum", 32'(sum2), 0);
    chk("w2_cout", 32'(cout2), 1);
    chk("w2_ovf", 32'(ovf2), 0);
    step();
    chk("w2_done_pulse", 32'(done2), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
